// File: rtl/prbs5_checker_pkg.sv
// Shared definitions for the PRBS5 checker: FSM encoding, generator taps, counter widths.
package prbs5_checker_pkg;

  typedef enum logic [1:0] {
    StFill   = 2'd0,
    StSearch = 2'd1,
    StLocked = 2'd2
  } state_e;

  // x^5 + x^2 + 1  =>  b[m] = b[m-3] ^ b[m-5]
  localparam int unsigned HistW   = 5;
  localparam int unsigned TapA    = 3;
  localparam int unsigned TapB    = 5;

  localparam int unsigned FillW   = 3;   // counts up to HistW valid bits
  localparam int unsigned CntW    = 8;   // match / consecutive-error counters
  localparam int unsigned ErrCntW = 16;

endpackage

// File: rtl/prbs5_predictor.sv
// History shift register of received bits and the PRBS5 prediction for the next bit.
module prbs5_predictor
  import prbs5_checker_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic bit_i,
  output logic pred_o,
  output logic hist_zero_o
);

  // hist_q[0] is the most recent received bit (m-1), hist_q[4] is m-5.
  logic [HistW-1:0] hist_q, hist_d;

  // Shift in the received bit (never the prediction) so the checker self-synchronises.
  always_comb begin
    hist_d = hist_q;
    if (valid_i) begin
      hist_d = {hist_q[HistW-2:0], bit_i};
    end
  end

  // History register, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign pred_o      = hist_q[TapA-1] ^ hist_q[TapB-1];
  assign hist_zero_o = (hist_q == '0);

endmodule

// File: rtl/prbs5_checker.sv
// PRBS5 stream checker: fills history, searches for LOCK_CNT clean predictions, then
// counts mismatches while locked and drops back to search on UNLOCK_ERR in a row.
module prbs5_checker
  import prbs5_checker_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_ERR = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  localparam logic [CntW-1:0]  LockCntC   = CntW'(LOCK_CNT);
  localparam logic [CntW-1:0]  UnlockErrC = CntW'(UNLOCK_ERR);
  localparam logic [FillW-1:0] FillLastC  = FillW'(HistW - 1);

  state_e              state_q, state_d;
  logic [FillW-1:0]    fill_q, fill_d;
  logic [CntW-1:0]     match_q, match_d;
  logic [CntW-1:0]     cons_q, cons_d;
  logic                err_pulse_q, err_pulse_d;
  logic [ErrCntW-1:0]  err_cnt_q, err_cnt_d;

  logic pred;
  logic hist_zero;
  logic mismatch;

  prbs5_predictor u_predictor (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (bit_valid),
    .bit_i       (bit_in),
    .pred_o      (pred),
    .hist_zero_o (hist_zero)
  );

  assign mismatch = bit_in ^ pred;

  // Next-state logic: FSM transitions, lock/unlock counters, error pulse and count.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    cons_d      = cons_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (bit_valid) begin
      unique case (state_q)
        StFill: begin
          fill_d = fill_q + 1'b1;
          if (fill_q == FillLastC) begin
            fill_d  = '0;
            state_d = StSearch;
          end
        end
        StSearch: begin
          // An all-zero history trivially predicts zero, so it never counts toward lock.
          if (!mismatch && !hist_zero) begin
            match_d = match_q + 1'b1;
            if (match_d == LockCntC) begin
              state_d = StLocked;
              match_d = '0;
              cons_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        StLocked: begin
          if (mismatch || hist_zero) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            cons_d = cons_q + 1'b1;
            if (cons_d == UnlockErrC) begin
              state_d = StSearch;
              match_d = '0;
              cons_d  = '0;
            end
          end else begin
            cons_d = '0;
          end
        end
        default: begin
          state_d = StFill;
        end
      endcase
    end

    // Clear beats a simultaneous increment.
    if (clr_cnt) begin
      err_cnt_d = '0;
    end
  end

  // State and counter registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFill;
      fill_q      <= '0;
      match_q     <= '0;
      cons_q      <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      cons_q      <= cons_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;

endmodule
